// File: rtl/pkt_tx_arbiter_pkg.sv
// pkt_tx_arbiter_pkg: shared defaults, FSM encoding and round-robin helper for the packet transmit arbiter
// Contents:
//   DEF_NUM_SRC / DEF_WORD_SIZE / DEF_WORDS_PER_PACKET  default geometry, matched to the RX assembler
//   state_t                                             FSM encoding (ST_ARB, ST_SEND)
//   rr_dist()                                           forward distance from the round-robin pointer
package pkt_tx_arbiter_pkg;

    localparam int DEF_NUM_SRC          = 2;
    localparam int DEF_WORD_SIZE        = 8;
    localparam int DEF_WORDS_PER_PACKET = 4;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // How many steps forward from ptr (modulo n) source idx sits; 0 means idx is the pointer itself.
    function automatic int rr_dist(input int idx, input int ptr, input int n);
        return (idx >= ptr) ? idx - ptr : idx + n - ptr;
    endfunction

endpackage

// File: rtl/pkt_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first requester at or after ptr modulo NUM_SRC
// Ports:
//   req        in   NUM_SRC          request vector
//   ptr        in   clog2(NUM_SRC)   highest-priority index this round
//   grant      out  NUM_SRC          one-hot grant, zero when no request
//   grant_idx  out  clog2(NUM_SRC)   index of the granted source, zero when no request
//   any        out  1                at least one request present
module rr_arbiter
    import pkt_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] ptr,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       any
);

    localparam int IW = $clog2(NUM_SRC);

    logic [IW:0] best;

    // Keep the requester with the smallest forward distance from ptr; NUM_SRC is an impossible distance.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        best      = (IW + 1)'(NUM_SRC);
        for (int j = 0; j < NUM_SRC; j++) begin
            if (req[j] && (IW + 1)'(rr_dist(j, int'(ptr), NUM_SRC)) < best) begin
                best      = (IW + 1)'(rr_dist(j, int'(ptr), NUM_SRC));
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pkt_tx_arbiter.sv
// pkt_tx_arbiter: round-robin share of one byte-wide UART transmitter among NUM_SRC packet sources
// Ports:
//   clk         in   1                              clock
//   n_reset     in   1                              synchronous active-low reset
//   src_req     in   NUM_SRC                        per-source request, held until src_ack
//   src_data    in   NUM_SRC*WORDS_PER_PACKET*WORD_SIZE  packet of source s at slice s
//   src_ack     out  NUM_SRC                        one-cycle one-hot pulse when a packet is latched
//   tx_data     out  WORD_SIZE                      word to the UART
//   tx_valid    out  1                              tx_data valid, held until tx_ready
//   tx_ready    in   1                              UART accepts when tx_valid && tx_ready
//   busy        out  1                              a packet is in flight
//   active_src  out  clog2(NUM_SRC)                 source whose packet is being sent
// Build option PKT_TX_SRC_ID_EN: prefix each packet with a header word holding the granted index.
module pkt_tx_arbiter
    import pkt_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC          = DEF_NUM_SRC,
    parameter int WORD_SIZE        = DEF_WORD_SIZE,
    parameter int WORDS_PER_PACKET = DEF_WORDS_PER_PACKET
) (
    input  logic                                      clk,
    input  logic                                      n_reset,
    input  logic [NUM_SRC-1:0]                        src_req,
    input  logic [NUM_SRC*WORDS_PER_PACKET*WORD_SIZE-1:0] src_data,
    output logic [NUM_SRC-1:0]                        src_ack,
    output logic [WORD_SIZE-1:0]                      tx_data,
    output logic                                      tx_valid,
    input  logic                                      tx_ready,
    output logic                                      busy,
    output logic [$clog2(NUM_SRC)-1:0]                active_src
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int PW = WORDS_PER_PACKET * WORD_SIZE;
    localparam int CW = $clog2(WORDS_PER_PACKET + 1);
`ifdef PKT_TX_SRC_ID_EN
    localparam int NW = WORDS_PER_PACKET + 1;
`else
    localparam int NW = WORDS_PER_PACKET;
`endif
    localparam int SW = NW * WORD_SIZE;

    state_t             state, state_nxt;
    logic [SW-1:0]      shift, load;
    logic [CW-1:0]      ctr;
    logic [IW-1:0]      rr_ptr, grant_idx;
    logic [NUM_SRC-1:0] grant;
    logic [PW-1:0]      pkt;
    logic               any, take, last;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req       (src_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // One-hot grant lets the packet mux be a plain OR of constant slices.
    always_comb begin
        pkt = '0;
        for (int j = 0; j < NUM_SRC; j++)
            if (grant[j]) pkt = src_data[j*PW +: PW];
    end

    // Header sits in the low word so it leaves the shift register first.
`ifdef PKT_TX_SRC_ID_EN
    assign load = {pkt, WORD_SIZE'(grant_idx)};
`else
    assign load = pkt;
`endif

    assign take = (state == ST_SEND) && tx_ready;
    assign last = ctr == CW'(NW - 1);

    always_ff @(posedge clk)
        state <= !n_reset ? ST_ARB : state_nxt;

    always_comb
        state_nxt = (state == ST_ARB) ? (any ? ST_SEND : ST_ARB)
                                      : ((take && last) ? ST_ARB : ST_SEND);

    always_comb begin
        tx_valid = state == ST_SEND;
        busy     = state == ST_SEND;
    end

    // Zeros shift in behind the packet, so tx_data reads 0 whenever nothing is in flight.
    assign tx_data = shift[WORD_SIZE-1:0];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            shift      <= '0;
            ctr        <= '0;
            rr_ptr     <= '0;
            active_src <= '0;
            src_ack    <= '0;
        end else begin
            src_ack <= (state == ST_ARB) ? grant : '0;
            if (state == ST_ARB && any) begin
                shift      <= load;
                ctr        <= '0;
                active_src <= grant_idx;
                rr_ptr     <= (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end else if (take) begin
                shift <= shift >> WORD_SIZE;
                ctr   <= ctr + 1'b1;
            end
        end
    end

endmodule
